matrix_scan_ctrl: RTL and testbench
===================================

# matrix_scan_ctrl

Row-scan controller for the 8x16 LED matrix. It sits between the digit-bitmap generator and the matrix drivers. It snapshots the 128-bit frame bitmap once per frame to prevent tearing, then drives one row at a time with a blanking gap between rows. Brightness is set by per-row on-time PWM. It also emits a frame-start strobe that upstream logic uses to update the displayed time.

## Interface
Parameters:
- PRESCALE, 8, clock cycles per row slot; must be a multiple of 8 and ≥ 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- frame  in  128  bitmap from the generator. Row r occupies bits [127-16r : 112-16r]; the row's MSB is column 15.
- enable  in  1  scan enable; 0 forces the display dark.
- brightness  in  3  on-time level 0..7.
- rowSel  out  8  one-hot active-high row select; bit r selects row r.
- colData  out  16  column drive for the selected row, active-high.
- frameStart  out  1  one-cycle pulse while a new frame is being latched.

## Operation
- FSM states: IDLE, LOAD, SCAN, BLANK. All outputs are decoded from registered state only; there is no combinational input-to-output path.
- IDLE
  - rowSel=0, colData=0, frameStart=0.
  - enable=1 → LOAD.
- LOAD (1 cycle)
  - Latch shadow<=frame and brightLat<=brightness; clear row and tick.
  - frameStart=1; rowSel=0, colData=0.
  - → SCAN.
- SCAN (PRESCALE cycles)
  - tick counts 0..PRESCALE-1.
  - onLen = (brightLat+1)*(PRESCALE/8).
  - While tick<onLen: rowSel = 1<<row and colData = shadow row[row].
  - Otherwise rowSel=0 and colData=0.
  - At tick=PRESCALE-1 → BLANK.
- BLANK (1 cycle)
  - Outputs zero; tick<=0.
  - row<7 → row<=row+1, → SCAN.
  - row=7 → LOAD. Row index wraps; a new frame and brightness are sampled.
- enable=0 in any state → IDLE on the next edge. Row, tick and shadow are not preserved. A later enable restarts at LOAD with row 0.
- frame and brightness changes outside LOAD have no effect until the next LOAD.
- rst=1 overrides everything, including enable.
  - Next state IDLE; row=0, tick=0, shadow=0, brightLat=0.
  - All outputs 0.
- rowSel is never multi-hot. colData is nonzero only when rowSel is nonzero.

## Timing
- Reset values: rowSel=0, colData=0, frameStart=0, state IDLE.
- enable sampled high at edge k (from IDLE):
  - LOAD during cycle k+1, with frameStart high.
  - First SCAN cycle is k+2, with row 0 lit if onLen>0.
- Frame period = 1 + 8*(PRESCALE+1) cycles. With PRESCALE=8 this is 73 cycles.
- frameStart pulses are exactly one frame period apart while enable stays high.
- The 1-cycle BLANK always separates consecutive rows, and the last row from LOAD.
- Brightness 7 → row lit for the full PRESCALE cycles. Brightness 0 → row lit for PRESCALE/8 cycles.
- enable low at edge k → outputs zero from cycle k+1.
- rst asserted mid-row → outputs zero from the next cycle; no partial row completes.

## Structure
- Shared package matrix_pkg holds:
  - constants MATRIX_ROWS=8, MATRIX_COLS=16, FRAME_W=128;
  - state enum {IDLE, LOAD, SCAN, BLANK};
  - function rowSlice(frame, r) returning the 16-bit row.
- The generator and this block share matrix_pkg.
- One sub-module, scan_tick_counter: PRESCALE-modulo counter with clear, exposing tick and a terminal-count flag. The FSM, shadow register and PWM compare stay in the top module.

## Test plan
All scenarios use PRESCALE=8.
- Reset: hold rst=1 with enable=1 and frame all ones for 5 cycles → rowSel=0, colData=0, frameStart=0 throughout. Release → frameStart high exactly 1 cycle later.
- Full-brightness scan:
  - Stimulus: frame with row r = 16'h0001<<r, brightness=7.
  - Response: each row lit for 8 consecutive cycles with rowSel=1<<r and colData=1<<r.
  - 1-cycle dark gap between rows; frameStart period 73 cycles.
- PWM: brightness=3 → onLen=4. Each row is lit for cycles tick 0..3, then dark for 4 cycles plus the BLANK cycle.
- Tear-free update: change frame while row 3 is lit → rows 3..7 of the current frame still show the old data. The new data appears starting at row 0 after the next frameStart.
- Enable mid-frame: deassert enable during row 5 → outputs 0 the next cycle. Re-assert → LOAD, then scanning resumes at row 0, not row 5.
- Invariant checker over random frame/brightness/enable stimulus:
  - rowSel is zero or one-hot at all times;
  - colData=0 whenever rowSel=0;
  - colData equals rowSlice(shadow, row) whenever a row is lit.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix display path (bitmap generator and scan controller).
// Latency: n/a (types, constants and a pure row-extraction helper only).
// Backpressure: n/a.
//
// Contents:
//   MATRIX_ROWS / MATRIX_COLS / FRAME_W  geometry of the 8x16 matrix and its flat bitmap
//   ROW_W                                width of a row index
//   scan_state_t                         scan controller FSM states
//   rowSlice(frame, r)                   16-bit column pattern of row r from a flat bitmap
package matrix_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 16;
  localparam int FRAME_W     = MATRIX_ROWS * MATRIX_COLS;
  localparam int ROW_W       = $clog2(MATRIX_ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SCAN  = 2'd2,
    BLANK = 2'd3
  } scan_state_t;

  // Row 0 lives in the most significant 16 bits of the bitmap, row 7 in the
  // least significant. Within a row, bit 15 is column 15. Written as a mux
  // over constant part-selects so it maps onto a plain 8:1 selector.
  function automatic logic [MATRIX_COLS-1:0] rowSlice(
    input logic [FRAME_W-1:0] frame,
    input logic [ROW_W-1:0]   r
  );
    logic [MATRIX_COLS-1:0] s;
    s = '0;
    for (int i = 0; i < MATRIX_ROWS; i++) begin
      if (r == ROW_W'(i)) begin
        s = frame[FRAME_W-1-MATRIX_COLS*i -: MATRIX_COLS];
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/scan_tick_counter.sv
// Row-slot timer: counts 0..PRESCALE-1 while running and flags the last cycle of the slot.
// Latency: tick updates one cycle after the edge; tc is decoded combinationally from tick.
// Backpressure: none; the counter free-runs whenever clr is low.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset, tick <= 0
//   clr   in   hold the counter at zero (used outside the SCAN state)
//   tick  out  current position inside the row slot
//   tc    out  high while tick == PRESCALE-1; the counter wraps to 0 after it
module scan_tick_counter #(
  parameter  int PRESCALE = 8,
  localparam int TW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic [TW-1:0] tick,
  output logic          tc
);

  assign tc = (tick == TW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tick <= '0;
    end else if (tc) begin
      tick <= '0;
    end else begin
      tick <= tick + TW'(1);
    end
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scan controller for the 8x16 LED matrix: latches a frame, scans rows with PWM on-time and blanking.
// Latency: enable high at edge k -> LOAD (frameStart) in cycle k+1, row 0 lit from cycle k+2.
// Backpressure: none; the display free-runs, frame/brightness are only sampled during LOAD.
//
// Parameters:
//   PRESCALE    clock cycles per row slot; a multiple of 8, at least 8
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset, overrides enable
//   frame       in   128-bit bitmap, row r at bits [127-16r : 112-16r]
//   enable      in   scan enable; low drops to IDLE and darkens the display next cycle
//   brightness  in   on-time level 0..7, row lit for (brightness+1)*PRESCALE/8 cycles
//   rowSel      out  one-hot active-high row select
//   colData     out  active-high column drive for the selected row
//   frameStart  out  one-cycle pulse while a new frame is being latched
//
// Frame period is 1 + 8*(PRESCALE+1) cycles: one LOAD, then per row a
// PRESCALE-cycle SCAN slot followed by one BLANK cycle. All outputs are
// decoded from registers only, so nothing on the inputs reaches the pins
// combinationally.
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FRAME_W-1:0]     frame,
  input  logic                   enable,
  input  logic [2:0]             brightness,
  output logic [MATRIX_ROWS-1:0] rowSel,
  output logic [MATRIX_COLS-1:0] colData,
  output logic                   frameStart
);

  localparam int TW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int STEP = PRESCALE / 8;
  // Wide enough for (7+1)*STEP = PRESCALE with headroom for the compare.
  localparam int OLW  = TW + 4;

  scan_state_t          state;
  scan_state_t          state_nxt;
  logic [ROW_W-1:0]     row;
  logic [FRAME_W-1:0]   shadow;
  logic [2:0]           bright_lat;
  logic [TW-1:0]        tick;
  logic                 tc;
  logic [OLW-1:0]       level;
  logic [OLW-1:0]       on_len;
  logic                 lit;

  // ---------------------------------------------------------------------------
  // Row-slot timer: only runs in SCAN, so LOAD and BLANK both leave it at 0
  // and every row slot starts from tick 0.
  // ---------------------------------------------------------------------------
  scan_tick_counter #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != SCAN),
    .tick (tick),
    .tc   (tc)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. Dropping enable wins from every state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = LOAD;
        LOAD:    state_nxt = SCAN;
        SCAN:    state_nxt = tc ? BLANK : SCAN;
        BLANK:   state_nxt = (row == ROW_W'(MATRIX_ROWS - 1)) ? LOAD : SCAN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: row index, frame snapshot and brightness snapshot.
  // The snapshot is what makes the display tear-free: frame/brightness are
  // only looked at during LOAD, never mid-frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      shadow     <= '0;
      bright_lat <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          row <= '0;
        end
        LOAD: begin
          row        <= '0;
          shadow     <= frame;
          bright_lat <= brightness;
        end
        BLANK: begin
          // Wraps 7 -> 0 on the way into LOAD, which clears it again anyway.
          row <= row + ROW_W'(1);
        end
        default: begin
          row <= row;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // PWM compare: the row is driven for the first on_len ticks of its slot.
  // ---------------------------------------------------------------------------
  assign level  = {{(OLW-3){1'b0}}, bright_lat} + OLW'(1);
  assign on_len = level * OLW'(STEP);
  assign lit    = (state == SCAN) && ({4'b0000, tick} < on_len);

  // ---------------------------------------------------------------------------
  // FSM: output decode. rowSel and colData share the single lit qualifier, so
  // colData can never be nonzero while rowSel is dark, and the shift of a
  // single bit keeps rowSel one-hot.
  // ---------------------------------------------------------------------------
  always_comb begin
    rowSel     = '0;
    colData    = '0;
    frameStart = 1'b0;
    if (state == LOAD) begin
      frameStart = 1'b1;
    end
    if (lit) begin
      rowSel  = MATRIX_ROWS'(1) << row;
      colData = rowSlice(shadow, row);
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl (PRESCALE=8) plus a randomised invariant phase.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled at the same point.
// Every comparison goes through chk(); the summary line prints the counters chk() steps.
module tb_matrix_scan_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] frame;
  logic         enable;
  logic [2:0]   brightness;
  logic [7:0]   rowSel;
  logic [15:0]  colData;
  logic         frameStart;

  int n_cmp = 0;
  int n_bad = 0;

  // Row 0 = 0x0001 ... row 7 = 0x0080, row 0 in the top 16 bits.
  localparam logic [127:0] DIAG = {16'h0001, 16'h0002, 16'h0004, 16'h0008,
                                   16'h0010, 16'h0020, 16'h0040, 16'h0080};
  localparam logic [127:0] PAT1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] PAT2 = 128'hFFFF_0000_A5A5_5A5A_8001_7FFE_00FF_FF00;

  always #5 clk = ~clk;

  matrix_scan_ctrl #(
    .PRESCALE (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame      (frame),
    .enable     (enable),
    .brightness (brightness),
    .rowSel     (rowSel),
    .colData    (colData),
    .frameStart (frameStart)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] vec(input logic fs, input logic [7:0] rs, input logic [15:0] cd);
    return {7'd0, fs, rs, cd};
  endfunction

  function automatic logic [31:0] obs();
    return vec(frameStart, rowSel, colData);
  endfunction

  // Expected 16-bit pattern of row r: shift the row down to the bottom.
  function automatic logic [15:0] exp_row(input logic [127:0] f, input int r);
    logic [127:0] s;
    s = f >> (16 * (7 - r));
    return s[15:0];
  endfunction

  // Entered while the DUT sits in LOAD. Walks the whole frame: 8 rows of
  // 8 SCAN cycles + 1 BLANK, then checks the next frameStart lands 73 cycles
  // after this one. Optionally changes the frame input during row chg_row,
  // or drops enable during row stop_row and returns after checking darkness.
  task automatic scan_frame(input string name, input logic [127:0] expf, input int b,
                            input int chg_row, input logic [127:0] newf, input int stop_row);
    int on_len;
    on_len = b + 1;
    chk($sformatf("%s_load", name), obs(), vec(1'b1, 8'h00, 16'h0000));
    for (int r = 0; r < 8; r++) begin
      for (int t = 0; t < 8; t++) begin
        cycle();
        if (t < on_len)
          chk($sformatf("%s_lit_r%0d_t%0d", name, r, t), obs(),
              vec(1'b0, 8'(1 << r), exp_row(expf, r)));
        else
          chk($sformatf("%s_pwm_r%0d_t%0d", name, r, t), obs(), vec(1'b0, 8'h00, 16'h0000));
        if (r == chg_row && t == 0) frame = newf;
        if (r == stop_row && t == 2) begin
          enable = 1'b0;
          cycle();
          chk($sformatf("%s_en_off", name), obs(), vec(1'b0, 8'h00, 16'h0000));
          return;
        end
      end
      cycle();
      chk($sformatf("%s_blank_r%0d", name, r), obs(), vec(1'b0, 8'h00, 16'h0000));
    end
    cycle();
    chk($sformatf("%s_period", name), obs(), vec(1'b1, 8'h00, 16'h0000));
  endtask

  logic [127:0] mshadow;

  initial begin
    rst        = 1'b1;
    enable     = 1'b1;
    frame      = '1;
    brightness = 3'd7;
    mshadow    = '0;

    // Reset dominates enable: everything dark for the whole hold.
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk($sformatf("rst_hold_%0d", i), obs(), vec(1'b0, 8'h00, 16'h0000));
    end
    rst = 1'b0;
    chk("rst_rel_pre", {31'd0, frameStart}, 32'd0);
    frame = DIAG;
    cycle();
    chk("rst_rel_fs", {31'd0, frameStart}, 32'd1);

    // Full brightness, diagonal pattern, then PWM levels 3 and 0.
    scan_frame("full", DIAG, 7, -1, '0, -1);
    brightness = 3'd3;
    frame      = PAT1;
    scan_frame("pwm3", PAT1, 3, -1, '0, -1);
    brightness = 3'd0;
    frame      = PAT2;
    scan_frame("pwm0", PAT2, 0, -1, '0, -1);

    // Tear-free: frame changes while row 3 is lit, old data must persist.
    brightness = 3'd7;
    frame      = PAT1;
    scan_frame("tear_old", PAT1, 7, 3, PAT2, -1);
    scan_frame("tear_new", PAT2, 7, -1, '0, 5);

    // Display stays dark while disabled; re-enable restarts at LOAD, row 0.
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk($sformatf("idle_%0d", i), obs(), vec(1'b0, 8'h00, 16'h0000));
    end
    frame  = DIAG;
    enable = 1'b1;
    cycle();
    scan_frame("restart", DIAG, 7, -1, '0, -1);

    // Random frame/brightness/enable with structural invariants.
    for (int i = 0; i < 800; i++) begin
      int idx;
      if ($urandom_range(0, 3) == 0) frame = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) brightness = 3'($urandom_range(0, 7));
      enable = ($urandom_range(0, 29) != 0);
      // LOAD latches whatever frame is presented at its closing edge.
      if (frameStart) mshadow = frame;
      cycle();
      chk($sformatf("inv_onehot_%0d", i), {31'd0, ($countones(rowSel) <= 1)}, 32'd1);
      if (rowSel == 8'h00) begin
        chk($sformatf("inv_dark_%0d", i), {16'd0, colData}, 32'd0);
      end else begin
        idx = 0;
        for (int j = 0; j < 8; j++) if (rowSel[j]) idx = j;
        chk($sformatf("inv_data_%0d", i), {16'd0, colData}, {16'd0, exp_row(mshadow, idx)});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
